// File: rtl/inner_prod_feeder.sv
// Buffers one A/B vector pair, streams it into Inner_Prod on start, then captures its result.
// Define INNER_PROD_FEEDER_CHECK_EN to add the exp_c input and sticky mismatch output.
module inner_prod_feeder #(
  parameter int unsigned VEC_LEN = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RES_W   = 19,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_en,
  input  logic [$clog2(VEC_LEN)-1:0] ld_idx,
  input  logic [DATA_W-1:0]          ld_a,
  input  logic [DATA_W-1:0]          ld_b,
  input  logic                       start,
  output logic                       busy,
  output logic                       valid_in,
  output logic [DATA_W-1:0]          A,
  output logic [DATA_W-1:0]          B,
  input  logic                       valid_out,
  input  logic [RES_W-1:0]           C,
  output logic [RES_W-1:0]           result,
  output logic                       done,
  output logic                       timeout,
`ifdef INNER_PROD_FEEDER_CHECK_EN
  input  logic [RES_W-1:0]           exp_c,
  output logic                       mismatch,
`endif
  output logic                       proto_err
);

  localparam int unsigned IDX_W = $clog2(VEC_LEN);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_in_q, valid_in_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               proto_err_q, proto_err_d;
`ifdef INNER_PROD_FEEDER_CHECK_EN
  logic               mismatch_q, mismatch_d;
`endif

  logic [DATA_W-1:0]  buf_a_q [VEC_LEN];
  logic [DATA_W-1:0]  buf_b_q [VEC_LEN];

  assign idx_nxt = idx_q + 1'b1;

  // Buffer is frozen outside IDLE so a running transaction always sends a consistent pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < VEC_LEN; i++) begin
        buf_a_q[i] <= '0;
        buf_b_q[i] <= '0;
      end
    end else if (ld_en && (state_q == StIdle)) begin
      buf_a_q[ld_idx] <= ld_a;
      buf_b_q[ld_idx] <= ld_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    valid_in_d  = 1'b0;
    a_d         = '0;
    b_d         = '0;
    result_d    = result_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;
`ifdef INNER_PROD_FEEDER_CHECK_EN
    mismatch_d  = mismatch_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSend;
          idx_d       = '0;
          cnt_d       = '0;
          valid_in_d  = 1'b1;
          // Forward a same-cycle write to element 0, the only one read at this edge.
          a_d         = (ld_en && (ld_idx == '0)) ? ld_a : buf_a_q[0];
          b_d         = (ld_en && (ld_idx == '0)) ? ld_b : buf_b_q[0];
          timeout_d   = 1'b0;
          proto_err_d = 1'b0;
`ifdef INNER_PROD_FEEDER_CHECK_EN
          mismatch_d  = 1'b0;
`endif
        end
      end
      StSend: begin
        if (idx_q == LAST_IDX) begin
          state_d = StWait;
          idx_d   = '0;
        end else begin
          idx_d      = idx_nxt;
          valid_in_d = 1'b1;
          a_d        = buf_a_q[idx_nxt];
          b_d        = buf_b_q[idx_nxt];
        end
      end
      StWait: begin
        if (valid_out) begin
          result_d = C;
          state_d  = StDone;
          done_d   = 1'b1;
          cnt_d    = '0;
`ifdef INNER_PROD_FEEDER_CHECK_EN
          mismatch_d = (C != exp_c);
`endif
        end else if (cnt_q == LAST_CNT) begin
          timeout_d = 1'b1;
          state_d   = StDone;
          done_d    = 1'b1;
          cnt_d     = '0;
`ifdef INNER_PROD_FEEDER_CHECK_EN
          mismatch_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Any response outside WAIT is either early or a repeated valid_out cycle.
    if (valid_out && (state_q != StWait)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      valid_in_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef INNER_PROD_FEEDER_CHECK_EN
      mismatch_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      valid_in_q  <= valid_in_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
`ifdef INNER_PROD_FEEDER_CHECK_EN
      mismatch_q  <= mismatch_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign valid_in  = valid_in_q;
  assign A         = a_q;
  assign B         = b_q;
  assign result    = result_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign proto_err = proto_err_q;
`ifdef INNER_PROD_FEEDER_CHECK_EN
  assign mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_inner_prod_feeder.sv
// Bench for inner_prod_feeder: acts as host and as a stand-in Inner_Prod,
// comparing against a vector-level reference model.
module tb_inner_prod_feeder;

  localparam int unsigned VEC_LEN = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RES_W   = 19;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned IDX_W   = $clog2(VEC_LEN);

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_a, ld_b;
  logic              start;
  logic              busy, valid_in, done, timeout, proto_err;
  logic [DATA_W-1:0] a_s, b_s;
  logic              valid_out;
  logic [RES_W-1:0]  c_s;
  logic [RES_W-1:0]  result;
`ifdef INNER_PROD_FEEDER_CHECK_EN
  logic [RES_W-1:0]  exp_c;
  logic              mismatch;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mdl_a [VEC_LEN];
  logic [DATA_W-1:0] mdl_b [VEC_LEN];
  logic [RES_W-1:0]  mdl_result;

  always #5 clk = ~clk;

  inner_prod_feeder #(
    .VEC_LEN (VEC_LEN),
    .DATA_W  (DATA_W),
    .RES_W   (RES_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .start     (start),
    .busy      (busy),
    .valid_in  (valid_in),
    .A         (a_s),
    .B         (b_s),
    .valid_out (valid_out),
    .C         (c_s),
    .result    (result),
    .done      (done),
    .timeout   (timeout),
`ifdef INNER_PROD_FEEDER_CHECK_EN
    .exp_c     (exp_c),
    .mismatch  (mismatch),
`endif
    .proto_err (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] ref_dot();
    int unsigned sum = 0;
    for (int i = 0; i < VEC_LEN; i++) sum += int'(mdl_a[i]) * int'(mdl_b[i]);
    return RES_W'(sum);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " valid_in"}, valid_in, 0);
    check({tag, " A"}, a_s, 0);
    check({tag, " B"}, b_s, 0);
    check({tag, " result"}, result, 0);
    check({tag, " done"}, done, 0);
    check({tag, " timeout"}, timeout, 0);
    check({tag, " proto_err"}, proto_err, 0);
`ifdef INNER_PROD_FEEDER_CHECK_EN
    check({tag, " mismatch"}, mismatch, 0);
`endif
  endtask

  task automatic load(input int idx, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    ld_en  = 1'b1;
    ld_idx = IDX_W'(idx);
    ld_a   = a;
    ld_b   = b;
    mdl_a[idx] = a;
    mdl_b[idx] = b;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // vo_delay: WAIT cycle index of the response (>= TIMEOUT means never); vo_len: response length.
  task automatic run_txn(input string name, input int vo_delay, input int vo_len,
                         input bit busy_poke, input bit fwd_ld, input bit bad_exp);
    int unsigned      stub_c;
    int               last_cyc;
    int               exp_done_cyc;
    bit               captured;
    bit               exp_vi;
    logic [RES_W-1:0] exp_res;
    logic [DATA_W-1:0] exp_a, exp_b;
`ifdef INNER_PROD_FEEDER_CHECK_EN
    bit               exp_mm;
`endif
    if (fwd_ld) begin
      ld_en  = 1'b1;
      ld_idx = '0;
      ld_a   = DATA_W'($urandom);
      ld_b   = DATA_W'($urandom);
      mdl_a[0] = ld_a;
      mdl_b[0] = ld_b;
    end
    captured     = (vo_delay < int'(TIMEOUT));
    exp_res      = captured ? ref_dot() : mdl_result;
    exp_done_cyc = captured ? VEC_LEN + 2 + vo_delay : VEC_LEN + TIMEOUT + 1;
`ifdef INNER_PROD_FEEDER_CHECK_EN
    exp_c  = bad_exp ? ref_dot() + 1'b1 : ref_dot();
    exp_mm = !captured || bad_exp;
`endif
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    ld_en  = 1'b0;
    stub_c = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= int'(VEC_LEN + TIMEOUT + 4); cyc++) begin
      exp_vi = (cyc <= int'(VEC_LEN));
      exp_a  = '0;
      exp_b  = '0;
      if (exp_vi) begin
        exp_a = mdl_a[cyc-1];
        exp_b = mdl_b[cyc-1];
      end
      check({name, " valid_in"}, valid_in, exp_vi);
      check({name, " A"}, a_s, exp_a);
      check({name, " B"}, b_s, exp_b);
      check({name, " done"}, done, cyc == exp_done_cyc);
      check({name, " busy"}, busy, cyc <= exp_done_cyc);
      if (cyc == 1) begin
        check({name, " timeout cleared"}, timeout, 0);
        check({name, " proto_err cleared"}, proto_err, 0);
`ifdef INNER_PROD_FEEDER_CHECK_EN
        check({name, " mismatch cleared"}, mismatch, 0);
`endif
      end
      if (valid_in) begin
        stub_c  += int'(a_s) * int'(b_s);
        last_cyc = cyc;
      end
      valid_out = (last_cyc > 0) && (cyc >= last_cyc + 1 + vo_delay) &&
                  (cyc < last_cyc + 1 + vo_delay + vo_len);
      c_s = valid_out ? RES_W'(stub_c) : RES_W'($urandom);
      if (busy_poke && cyc == 3) begin
        start  = 1'b1;
        ld_en  = 1'b1;
        ld_idx = '0;
        ld_a   = 8'hFF;
        ld_b   = 8'hFF;
      end else begin
        start = 1'b0;
        ld_en = 1'b0;
      end
      @(negedge clk);
    end
    valid_out = 1'b0;
    check({name, " result"}, result, exp_res);
    check({name, " timeout"}, timeout, !captured);
    check({name, " proto_err"}, proto_err, captured && (vo_len > 1));
`ifdef INNER_PROD_FEEDER_CHECK_EN
    check({name, " mismatch"}, mismatch, exp_mm);
`endif
    mdl_result = exp_res;
  endtask

  initial begin
    logic [DATA_W-1:0] va [VEC_LEN];
    logic [DATA_W-1:0] vb [VEC_LEN];
    int                d;
    va = '{8'h01, 8'hB2, 8'h31, 8'h15, 8'hE3, 8'hD0, 8'hFF, 8'hCB};
    vb = '{8'h3D, 8'h15, 8'h99, 8'hA6, 8'h72, 8'h5B, 8'h4E, 8'h53};
    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_a = '0; ld_b = '0;
    start = 1'b0; valid_out = 1'b0; c_s = '0;
`ifdef INNER_PROD_FEEDER_CHECK_EN
    exp_c = '0;
`endif
    for (int i = 0; i < VEC_LEN; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
    mdl_result = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Response while idle is a protocol error.
    valid_out = 1'b1;
    @(negedge clk);
    valid_out = 1'b0;
    check("idle valid_out proto_err", proto_err, 1);
    check("idle valid_out busy", busy, 0);

    for (int i = 0; i < VEC_LEN; i++) load(i, va[i], vb[i]);
    run_txn("nominal", 0, 1, 1'b0, 1'b0, 1'b0);
    check("nominal known C", result, 19'h17847);

    run_txn("timeout", TIMEOUT, 0, 1'b0, 1'b0, 1'b0);
    check("timeout keeps C", result, 19'h17847);

    run_txn("double valid_out", 0, 2, 1'b0, 1'b0, 1'b1);
    run_txn("busy poke", 1, 1, 1'b1, 1'b0, 1'b0);
    run_txn("after poke", 0, 1, 1'b0, 1'b0, 1'b0);
    check("after poke A0 kept", mdl_a[0], 8'h01);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        if ($urandom_range(0, 3) != 0) load(i, DATA_W'($urandom), DATA_W'($urandom));
      end
      d = int'($urandom_range(0, TIMEOUT));
      run_txn("random", d, (d >= int'(TIMEOUT)) ? 0 : int'($urandom_range(1, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of SEND must clear outputs without waiting for a clock edge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset valid_in", valid_in, 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < VEC_LEN; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
    mdl_result = '0;
    @(negedge clk);
    check("post-reset idle busy", busy, 0);
    load(2, 8'h10, 8'h20);
    run_txn("post-reset", 0, 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
